uart_tx_cfg: RTL and testbench

- Parametrised, runtime-configurable UART transmitter; next generation of the system's fixed 8-bit TX path.
- Sits between the system controller / ALU result path and the serial pin.
- Adds an internal baud prescaler, runtime data length, 1 or 2 stop bits, a valid/ready input handshake, and a one-entry holding buffer for back-to-back frames.

---
 rtl/uart_tx_cfg.sv | 265 ++++++++++++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: runtime-configurable UART transmitter with a one-word holding buffer.
// Optional line-break generator: define UART_TX_BREAK_EN to add send_break and the BREAK state.
module uart_tx_cfg #(
  parameter int MAX_WIDTH = 8,
  parameter int DIV_W     = 16,
  parameter int LEN_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIV_W-1:0]     baud_div,
  input  logic [LEN_W-1:0]     data_len,
  input  logic                 par_en,
  input  logic                 par_typ,
  input  logic                 stop2,
`ifdef UART_TX_BREAK_EN
  input  logic                 send_break,
`endif
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [MAX_WIDTH-1:0] s_data,
  output logic                 tx_out,
  output logic                 busy,
  output logic                 frame_done
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP1,
    ST_STOP2
`ifdef UART_TX_BREAK_EN
    , ST_BREAK
`endif
  } state_t;

  state_t               state_q, state_d;
  logic [MAX_WIDTH-1:0] buf_q, buf_d;
  logic                 buf_full_q, buf_full_d;
  logic [MAX_WIDTH-1:0] shift_q, shift_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [DIV_W-1:0]     pre_q, pre_d;
  logic [LEN_W:0]       bit_q, bit_d;
  logic                 par_en_q, par_en_d;
  logic                 par_bit_q, par_bit_d;
  logic                 stop2_q, stop2_d;
  logic                 tx_q, tx_d;
  logic                 rdy_q, rdy_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [DIV_W-1:0]     div_eff;
  logic [LEN_W-1:0]     len_eff;
  logic [MAX_WIDTH-1:0] len_mask;
  logic                 par_calc;
  logic                 bit_end;
  logic                 last_data;
  logic                 accept;
  logic                 load;
  logic                 fin;
  logic                 from_brk;

`ifdef UART_TX_BREAK_EN
  logic                 brk_q, brk_d;
  logic                 last_brk;
  assign from_brk = brk_q;
  assign last_brk = (bit_q == ({1'b0, len_q} + (LEN_W+1)'(par_en_q) + (LEN_W+1)'(1)));
`else
  assign from_brk = 1'b0;
`endif

  // Clamped configuration, sampled only when a frame (or break) begins.
  always_comb begin
    div_eff  = (baud_div == '0) ? DIV_W'(1) : baud_div;
    len_eff  = ((data_len == '0) || (data_len > LEN_W'(MAX_WIDTH))) ? LEN_W'(MAX_WIDTH) : data_len;
    len_mask = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      len_mask[i] = (i < int'(len_eff));
    end
    par_calc = (^(buf_q & len_mask)) ^ par_typ;
  end

  assign bit_end   = (pre_q == (div_q - DIV_W'(1)));
  assign last_data = (bit_q == ({1'b0, len_q} - (LEN_W+1)'(1)));
  assign accept    = s_valid & rdy_q;

  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    shift_d    = shift_q;
    len_d      = len_q;
    div_d      = div_q;
    pre_d      = pre_q;
    bit_d      = bit_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    stop2_d    = stop2_q;
    tx_d       = tx_q;
    done_d     = 1'b0;
    load       = 1'b0;
    fin        = 1'b0;
`ifdef UART_TX_BREAK_EN
    brk_d      = brk_q;
`endif

    if (state_q != ST_IDLE) begin
      pre_d = bit_end ? '0 : pre_q + DIV_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
`ifdef UART_TX_BREAK_EN
        if (send_break) begin
          state_d  = ST_BREAK;
          tx_d     = 1'b0;
          pre_d    = '0;
          bit_d    = '0;
          len_d    = len_eff;
          div_d    = div_eff;
          par_en_d = par_en;
          stop2_d  = 1'b0;
          brk_d    = 1'b1;
        end else
`endif
        if (buf_full_q) begin
          load = 1'b1;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          tx_d    = shift_q[0];
          bit_d   = '0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (last_data) begin
            state_d = par_en_q ? ST_PARITY : ST_STOP1;
            tx_d    = par_en_q ? par_bit_q : 1'b1;
          end else begin
            shift_d = shift_q >> 1;
            tx_d    = shift_d[0];
            bit_d   = bit_q + (LEN_W+1)'(1);
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_d = ST_STOP1;
          tx_d    = 1'b1;
        end
      end
      ST_STOP1: begin
        if (bit_end) begin
          if (stop2_q) state_d = ST_STOP2;
          else         fin     = 1'b1;
        end
      end
      ST_STOP2: begin
        if (bit_end) fin = 1'b1;
      end
`ifdef UART_TX_BREAK_EN
      ST_BREAK: begin
        if (bit_end) begin
          if (last_brk) begin
            state_d = ST_STOP1;
            tx_d    = 1'b1;
            bit_d   = '0;
          end else begin
            bit_d   = bit_q + (LEN_W+1)'(1);
          end
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // A word that arrived during a frame follows it with no idle bit; after a break the line idles once.
    if (fin) begin
      done_d = 1'b1;
      if (buf_full_q && !from_brk) load = 1'b1;
      else                         state_d = ST_IDLE;
    end

    if (load) begin
      state_d    = ST_START;
      shift_d    = buf_q;
      buf_full_d = 1'b0;
      len_d      = len_eff;
      div_d      = div_eff;
      par_en_d   = par_en;
      par_bit_d  = par_calc;
      stop2_d    = stop2;
      pre_d      = '0;
      bit_d      = '0;
      tx_d       = 1'b0;
`ifdef UART_TX_BREAK_EN
      brk_d      = 1'b0;
`endif
    end

    if (accept) begin
      buf_d      = s_data;
      buf_full_d = 1'b1;
    end

    rdy_d  = !buf_full_d;
    busy_d = (state_d != ST_IDLE) | buf_full_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      shift_q    <= '0;
      len_q      <= '0;
      div_q      <= DIV_W'(1);
      pre_q      <= '0;
      bit_q      <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
      tx_q       <= 1'b1;
      rdy_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef UART_TX_BREAK_EN
      brk_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      shift_q    <= shift_d;
      len_q      <= len_d;
      div_q      <= div_d;
      pre_q      <= pre_d;
      bit_q      <= bit_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      stop2_q    <= stop2_d;
      tx_q       <= tx_d;
      rdy_q      <= rdy_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef UART_TX_BREAK_EN
      brk_q      <= brk_d;
`endif
    end
  end

  assign tx_out     = tx_q;
  assign s_ready    = rdy_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: directed and randomized frames checked cycle by cycle against a
// bit-list model of the UART frame format.
module tb_uart_tx_cfg;

  logic        clk;
  logic        rst;
  logic [15:0] baud_div;
  logic [3:0]  data_len;
  logic        par_en;
  logic        par_typ;
  logic        stop2;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        tx_out;
  logic        busy;
  logic        frame_done;
`ifdef UART_TX_BREAK_EN
  logic        send_break;
`endif

  uart_tx_cfg #(.MAX_WIDTH(8), .DIV_W(16), .LEN_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .baud_div   (baud_div),
    .data_len   (data_len),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .stop2      (stop2),
`ifdef UART_TX_BREAK_EN
    .send_break (send_break),
`endif
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .tx_out     (tx_out),
    .busy       (busy),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef bit bq_t[$];

  int  n_assert = 0;
  int  n_fail   = 0;
  bq_t exp_tx, exp_done, exp_busy, exp_rdy, got_tx;
  int  done_ks[$];
  int  cfg_div, cfg_len;
  bit  cfg_pe, cfg_pt, cfg_s2;

  task automatic chk(input string tag, input int k, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, got, exp);
    end
  endtask

  // Serial line waveform of one frame, one entry per clock, from the frame format rules.
  function automatic bq_t frame_wave(input logic [7:0] d, input int div, input int len,
                                     input bit pe, input bit pt, input bit s2);
    bq_t bits, w;
    int  ones, ed, el;
    ones = 0;
    ed = (div == 0) ? 1 : div;
    el = (len == 0 || len > 8) ? 8 : len;
    bits.push_back(1'b0);
    for (int i = 0; i < el; i++) begin
      bits.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (pe) bits.push_back(bit'(ones % 2) ^ pt);
    bits.push_back(1'b1);
    if (s2) bits.push_back(1'b1);
    foreach (bits[i]) for (int j = 0; j < ed; j++) w.push_back(bits[i]);
    return w;
  endfunction

  task automatic set_cfg(input int div, input int len, input bit pe, input bit pt, input bit s2);
    cfg_div = div; cfg_len = len; cfg_pe = pe; cfg_pt = pt; cfg_s2 = s2;
    baud_div = 16'(div);
    data_len = 4'(len);
    par_en   = pe;
    par_typ  = pt;
    stop2    = s2;
  endtask

  task automatic clear_exp();
    exp_tx.delete(); exp_done.delete(); exp_busy.delete(); exp_rdy.delete();
  endtask

  task automatic push(input bit tx, input bit dn, input bit bz, input bit rd);
    exp_tx.push_back(tx); exp_done.push_back(dn); exp_busy.push_back(bz); exp_rdy.push_back(rd);
  endtask

  // Expected per-cycle outputs, indexed from the first negedge after the acceptance edge.
  task automatic build(input int nw, input logic [7:0] w0, input logic [7:0] w1, input int inj);
    bq_t f0, f1;
    f0 = frame_wave(w0, cfg_div, cfg_len, cfg_pe, cfg_pt, cfg_s2);
    clear_exp();
    push(1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < f0.size(); i++)
      push(f0[i], 1'b0, 1'b1, (nw == 2 && i + 1 > inj) ? 1'b0 : 1'b1);
    if (nw == 2) begin
      f1 = frame_wave(w1, cfg_div, cfg_len, cfg_pe, cfg_pt, cfg_s2);
      for (int i = 0; i < f1.size(); i++) push(f1[i], i == 0, 1'b1, 1'b1);
    end
    push(1'b1, 1'b1, 1'b0, 1'b1);
    push(1'b1, 1'b0, 1'b0, 1'b1);
    push(1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic send(input logic [7:0] d);
    @(negedge clk);
    chk("ready_before_send", 0, 32'(s_ready), 32'd1);
    s_valid = 1'b1;
    s_data  = d;
  endtask

  task automatic capture(input string name, input int n, input int inj, input logic [7:0] dat);
    bit clr;
    clr = 1'b1;
    got_tx.delete();
    done_ks.delete();
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (clr) begin s_valid = 1'b0; clr = 1'b0; end
`ifdef UART_TX_BREAK_EN
      send_break = 1'b0;
`endif
      chk({name, "_tx"},    k, 32'(tx_out),     32'(exp_tx[k]));
      chk({name, "_done"},  k, 32'(frame_done), 32'(exp_done[k]));
      chk({name, "_busy"},  k, 32'(busy),       32'(exp_busy[k]));
      chk({name, "_ready"}, k, 32'(s_ready),    32'(exp_rdy[k]));
      got_tx.push_back(tx_out);
      if (frame_done === 1'b1) done_ks.push_back(k);
      if (k == inj) begin s_valid = 1'b1; s_data = dat; end
      if (s_valid && s_ready) clr = 1'b1;
    end
  endtask

  function automatic int done_at(input int idx);
    return (done_ks.size() > idx) ? done_ks[idx] : -1;
  endfunction

  task automatic single(input string name, input logic [7:0] d);
    build(1, d, 8'h00, -1);
    send(d);
    capture(name, exp_tx.size(), -1, 8'h00);
  endtask

  initial begin
    logic [0:9] a5_seq;
    logic [7:0] w0, w1;
    int         len_f, inj;
    bq_t        fb;

    a5_seq  = 10'b0101001011;
    rst     = 1'b0;
    s_valid = 1'b0;
    s_data  = 8'h00;
`ifdef UART_TX_BREAK_EN
    send_break = 1'b0;
`endif
    set_cfg(4, 8, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("rst_tx",    0, 32'(tx_out),     32'd1);
    chk("rst_ready", 0, 32'(s_ready),    32'd1);
    chk("rst_busy",  0, 32'(busy),       32'd0);
    chk("rst_done",  0, 32'(frame_done), 32'd0);
    rst = 1'b1;

    // 0xA5, 8N1, 4 clocks per bit
    single("a5", 8'hA5);
    chk("a5_first_low", 1, 32'(got_tx[1]), 32'd0);
    for (int b = 0; b < 10; b++) chk("a5_bit", b, 32'(got_tx[1 + 4*b + 2]), 32'(a5_seq[b]));
    chk("a5_done_cycle", 0, 32'(done_at(0)), 32'd41);

    // 0x53, 7 data bits (four ones), even then odd parity, then two stop bits
    set_cfg(4, 7, 1'b1, 1'b0, 1'b0);
    single("p_even", 8'h53);
    chk("p_even_bit", 33, 32'(got_tx[33 + 2]), 32'd0);
    set_cfg(4, 7, 1'b1, 1'b1, 1'b0);
    single("p_odd", 8'h53);
    chk("p_odd_bit", 33, 32'(got_tx[33 + 2]), 32'd1);
    set_cfg(4, 7, 1'b1, 1'b0, 1'b1);
    single("p_stop2", 8'h53);
    chk("p_stop2_len", 0, 32'(done_at(0)), 32'd45);

    // Back-to-back: second word accepted while the first is in DATA
    set_cfg(4, 8, 1'b0, 1'b0, 1'b0);
    build(2, 8'h0F, 8'hF0, 10);
    send(8'h0F);
    capture("b2b", exp_tx.size(), 10, 8'hF0);
    chk("b2b_gap", 0, 32'(done_at(1) - done_at(0)), 32'd40);

    // Clamping of baud_div and data_len
    set_cfg(0, 8, 1'b0, 1'b0, 1'b0);
    single("div0", 8'h6D);
    chk("div0_len", 0, 32'(done_at(0)), 32'd11);
    set_cfg(1, 8, 1'b0, 1'b0, 1'b0);
    single("div1", 8'h92);
    chk("div1_len", 0, 32'(done_at(0)), 32'd11);
    set_cfg(2, 0, 1'b0, 1'b0, 1'b0);
    single("len0", 8'hC3);
    chk("len0_len", 0, 32'(done_at(0)), 32'd21);
    set_cfg(2, 12, 1'b0, 1'b0, 1'b0);
    single("len12", 8'h3C);
    chk("len12_len", 0, 32'(done_at(0)), 32'd21);

    // Randomized configurations, some back-to-back
    for (int r = 0; r < 12; r++) begin
      set_cfg($urandom_range(5, 0), $urandom_range(12, 0), 1'($urandom_range(1, 0)),
              1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
      w0 = 8'($urandom);
      w1 = 8'($urandom);
      fb = frame_wave(w0, cfg_div, cfg_len, cfg_pe, cfg_pt, cfg_s2);
      len_f = fb.size();
      if ($urandom_range(1, 0) == 1) begin
        inj = $urandom_range(len_f - 1, 1);
        build(2, w0, w1, inj);
        send(w0);
        capture("rand_b2b", exp_tx.size(), inj, w1);
      end else begin
        build(1, w0, 8'h00, -1);
        send(w0);
        capture("rand", exp_tx.size(), -1, 8'h00);
      end
    end

    // Reset during DATA bit 3 with a word buffered
    set_cfg(4, 8, 1'b0, 1'b0, 1'b0);
    build(2, 8'h3C, 8'h99, 6);
    send(8'h3C);
    capture("pre_rst", 18, 6, 8'h99);
    #2 rst = 1'b0;
    #1;
    chk("midrst_tx",    0, 32'(tx_out),     32'd1);
    chk("midrst_ready", 0, 32'(s_ready),    32'd1);
    chk("midrst_busy",  0, 32'(busy),       32'd0);
    chk("midrst_done",  0, 32'(frame_done), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      chk("postrst_tx",   k, 32'(tx_out),     32'd1);
      chk("postrst_busy", k, 32'(busy),       32'd0);
      chk("postrst_done", k, 32'(frame_done), 32'd0);
    end
    single("after_rst", 8'h81);

`ifdef UART_TX_BREAK_EN
    // Break: 22 low clocks, one 2-clock stop bit, then the word buffered during the break
    set_cfg(2, 8, 1'b1, 1'b0, 1'b0);
    clear_exp();
    for (int k = 0; k < 22; k++) push(1'b0, 1'b0, 1'b1, (k <= 3) ? 1'b1 : 1'b0);
    push(1'b1, 1'b0, 1'b1, 1'b0);
    push(1'b1, 1'b0, 1'b1, 1'b0);
    push(1'b1, 1'b1, 1'b1, 1'b0);
    fb = frame_wave(8'h5A, 2, 8, 1'b1, 1'b0, 1'b0);
    foreach (fb[i]) push(fb[i], 1'b0, 1'b1, 1'b1);
    push(1'b1, 1'b1, 1'b0, 1'b1);
    push(1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    send_break = 1'b1;
    capture("brk", exp_tx.size(), 3, 8'h5A);
    chk("brk_done_cycle", 0, 32'(done_at(0)), 32'd24);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
